// File: rtl/dcro_freq_det_pkg.sv
// dcro_pkg: definitions shared by the DCRO frequency detector and the DCRO
// select-word controller.
//   - DCRO_SEL_LEN : default select width, so detector and controller agree
//   - state_t      : detector FSM states
//   - sel_max/min  : saturation limits of a (sel_len+1)-bit signed increment
package dcro_pkg;

  localparam int DCRO_SEL_LEN = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    COMPUTE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  // Largest value representable in a (sel_len+1)-bit two's complement word.
  function automatic int sel_max(input int sel_len);
    return (1 << sel_len) - 1;
  endfunction

  // Smallest value representable in a (sel_len+1)-bit two's complement word.
  function automatic int sel_min(input int sel_len);
    return -(1 << sel_len);
  endfunction

endpackage

// File: rtl/dcro_freq_det_if.sv
// dcro_freq_det_if: control/result bundle between the frequency detector and
// its surroundings (enable/target in, controller drive and status out).
//   en        : run enable
//   target    : expected edges per window (unsigned)
//   err_out   : signed word for the controller's sel_in
//   mode_out  : controller mode (0 absolute, 1 incremental)
//   err_valid : one-cycle strobe marking an increment
//   meas_cnt  : last completed window edge count
//   locked    : frequency lock indication
// master = the detector side, slave = the side driving en/target.
interface dcro_freq_det_if
  import dcro_pkg::*;
#(
  parameter int SEL_LEN = DCRO_SEL_LEN,
  parameter int CNT_W   = 16
);
  logic                      en;
  logic [CNT_W-1:0]          target;
  logic signed [SEL_LEN:0]   err_out;
  logic                      mode_out;
  logic                      err_valid;
  logic [CNT_W-1:0]          meas_cnt;
  logic                      locked;

  modport master (
    input  en, target,
    output err_out, mode_out, err_valid, meas_cnt, locked
  );

  modport slave (
    output en, target,
    input  err_out, mode_out, err_valid, meas_cnt, locked
  );
endinterface

// File: rtl/dcro_freq_det_osc_edge_sync.sv
// osc_edge_sync: brings the asynchronous DCRO output into the clk domain with
// a 2-flop synchronizer and produces a registered one-cycle pulse per rising
// edge.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   osc_in : DCRO output (asynchronous, below f_clk/2)
//   edge_p : one-cycle pulse, 3 clk after the edge reaches the first flop
module osc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_in,
  output logic edge_p
);
  logic sync1_reg;
  logic sync2_reg;
  logic sync2_d_reg;
  logic edge_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      sync2_d_reg <= 1'b0;
      edge_reg    <= 1'b0;
    end else begin
      sync1_reg   <= osc_in;
      sync2_reg   <= sync1_reg;
      sync2_d_reg <= sync2_reg;
      // rising edge: synchronized level high now, low one cycle earlier
      edge_reg    <= sync2_reg & ~sync2_d_reg;
    end
  end

  assign edge_p = edge_reg;
endmodule

// File: rtl/dcro_freq_det.sv
// dcro_freq_det: counter-based frequency detector driving the DCRO select-word
// controller. Counts DCRO rising edges over WIN_LEN clk cycles, compares with
// the target, and once per window emits a scaled, saturated signed increment
// in incremental mode. While disabled it holds the controller in absolute
// mode at INIT_SEL.
//   clk    : system clock (single domain)
//   rst_n  : asynchronous active-low reset
//   osc_in : DCRO output, asynchronous
//   bus    : dcro_freq_det_if master (en/target in; err_out, mode_out,
//            err_valid, meas_cnt, locked out -- all registered)
module dcro_freq_det
  import dcro_pkg::*;
#(
  parameter int SEL_LEN    = DCRO_SEL_LEN,
  parameter int CNT_W      = 16,
  parameter int WIN_LEN    = 1024,
  parameter int GAIN_SHIFT = 2,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_CNT   = 4,
  parameter int INIT_SEL   = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   osc_in,
  dcro_freq_det_if.master        bus
);
  localparam int WIN_W  = $clog2(WIN_LEN);
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
  localparam logic [WIN_W-1:0]    WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [LOCK_W-1:0]   LOCK_FULL = LOCK_W'(LOCK_CNT);
  localparam logic signed [SEL_LEN:0] INIT_WORD = (SEL_LEN+1)'(INIT_SEL);

  state_t state_reg, state_next;

  logic [WIN_W-1:0]   win_cnt_reg;
  logic [CNT_W-1:0]   edge_cnt_reg;
  logic [CNT_W-1:0]   target_reg;
  logic [LOCK_W-1:0]  lock_run_reg;

  logic signed [SEL_LEN:0] err_out_reg;
  logic                    mode_out_reg;
  logic                    err_valid_reg;
  logic [CNT_W-1:0]        meas_cnt_reg;
  logic                    locked_reg;

  logic edge_p;
  logic win_last;

  // arithmetic evaluated while in COMPUTE
  logic signed [CNT_W:0]   diff;
  logic signed [CNT_W:0]   q;
  logic [CNT_W:0]          abs_diff;
  int                      q_int;
  logic signed [SEL_LEN:0] q_sat;
  logic                    in_tol;
  logic [LOCK_W-1:0]       lock_run_next;

  osc_edge_sync u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_in),
    .edge_p (edge_p)
  );

  assign win_last = (win_cnt_reg == WIN_LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.en) state_next = MEASURE;
      MEASURE: begin
        if (!bus.en)       state_next = IDLE;
        else if (win_last) state_next = COMPUTE;
      end
      COMPUTE: state_next = bus.en ? OUTPUT : IDLE;
      OUTPUT:  state_next = bus.en ? MEASURE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------- arithmetic
  always_comb begin
    diff     = $signed({1'b0, target_reg}) - $signed({1'b0, edge_cnt_reg});
    q        = diff >>> GAIN_SHIFT;
    abs_diff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    in_tol   = (int'(abs_diff) <= LOCK_TOL);
    q_int    = int'(q);

    if (q_int > sel_max(SEL_LEN)) begin
      q_sat = (SEL_LEN+1)'(sel_max(SEL_LEN));
    end else if (q_int < sel_min(SEL_LEN)) begin
      q_sat = (SEL_LEN+1)'(sel_min(SEL_LEN));
    end else begin
      q_sat = q[SEL_LEN:0];
    end

    if (!in_tol) begin
      lock_run_next = '0;
    end else if (lock_run_reg == LOCK_FULL) begin
      lock_run_next = lock_run_reg;
    end else begin
      lock_run_next = lock_run_reg + LOCK_W'(1);
    end
  end

  // ------------------------------------------------ counters and target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_reg  <= '0;
      edge_cnt_reg <= '0;
      target_reg   <= '0;
      lock_run_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          win_cnt_reg  <= '0;
          edge_cnt_reg <= '0;
          lock_run_reg <= '0;
          if (bus.en) target_reg <= bus.target;
        end
        MEASURE: begin
          if (!bus.en) begin
            win_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            lock_run_reg <= '0;
          end else begin
            win_cnt_reg <= win_last ? '0 : win_cnt_reg + WIN_W'(1);
            // the final window cycle still counts its edge; the count then
            // holds through COMPUTE so later edges are discarded
            if (edge_p && edge_cnt_reg != CNT_MAX) begin
              edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
            end
          end
        end
        COMPUTE: begin
          if (bus.en) begin
            lock_run_reg <= lock_run_next;
          end else begin
            edge_cnt_reg <= '0;
            lock_run_reg <= '0;
          end
        end
        OUTPUT: begin
          win_cnt_reg  <= '0;
          edge_cnt_reg <= '0;
          if (bus.en) target_reg   <= bus.target;
          else        lock_run_reg <= '0;
        end
        default: begin
          win_cnt_reg  <= '0;
          edge_cnt_reg <= '0;
          lock_run_reg <= '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------ outputs
  // Registered from the next state so each output is valid during the
  // cycle its state occupies; err_out is zero in incremental mode except
  // for the single OUTPUT cycle, since the controller accumulates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_out_reg   <= INIT_WORD;
      mode_out_reg  <= 1'b0;
      err_valid_reg <= 1'b0;
      meas_cnt_reg  <= '0;
      locked_reg    <= 1'b0;
    end else begin
      mode_out_reg  <= (state_next != IDLE);
      err_valid_reg <= (state_next == OUTPUT);
      unique case (state_next)
        IDLE: begin
          err_out_reg <= INIT_WORD;
          locked_reg  <= 1'b0;
        end
        OUTPUT: begin
          err_out_reg  <= q_sat;
          meas_cnt_reg <= edge_cnt_reg;
          locked_reg   <= (lock_run_next == LOCK_FULL);
        end
        default: begin
          err_out_reg <= '0;
        end
      endcase
    end
  end

  assign bus.err_out   = err_out_reg;
  assign bus.mode_out  = mode_out_reg;
  assign bus.err_valid = err_valid_reg;
  assign bus.meas_cnt  = meas_cnt_reg;
  assign bus.locked    = locked_reg;

endmodule

// File: tb/tb_dcro_freq_det.sv
module tb_dcro_freq_det;
  import dcro_pkg::*;

  localparam int SEL_LEN    = 8;
  localparam int CNT_W      = 16;
  localparam int WIN_LEN    = 64;
  localparam int GAIN_SHIFT = 2;
  localparam int LOCK_TOL   = 2;
  localparam int LOCK_CNT   = 4;
  localparam int INIT_SEL   = 128;
  localparam int PERIOD     = WIN_LEN + 2;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic osc_in = 1'b0;

  dcro_freq_det_if #(.SEL_LEN(SEL_LEN), .CNT_W(CNT_W)) bus ();

  dcro_freq_det #(
    .SEL_LEN(SEL_LEN), .CNT_W(CNT_W), .WIN_LEN(WIN_LEN),
    .GAIN_SHIFT(GAIN_SHIFT), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT),
    .INIT_SEL(INIT_SEL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int meas;
    int err;
    int lck;
    bit chk_gap;
  } exp_t;

  exp_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int strobe_cnt  = 0;
  int osc_per     = 0;
  longint cyc         = 0;
  longint last_strobe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int meas, input int err, input int lck, input bit gap);
    exp_t e;
    e.meas = meas; e.err = err; e.lck = lck; e.chk_gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (strobe_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (strobe_cnt < n) begin
      vectors++;
      miscompares++;
      $display("FAIL strobe_timeout actual=%0d required=%0d", strobe_cnt, n);
    end
  endtask

  // oscillator model: osc_per clk cycles per period, 0 = silent
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (osc_per == 0) begin
        osc_in = 1'b0;
        ph = 0;
      end else begin
        ph = (ph + 1) % osc_per;
        osc_in = (ph < osc_per / 2);
      end
    end
  end

  // monitor: pops one expectation per strobe; between strobes in
  // incremental mode err_out must stay zero
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.err_valid) begin
        strobe_cnt++;
        $display("strobe %0d: meas_cnt=%0d err_out=%0d locked=%0d gap=%0d",
                 strobe_cnt, bus.meas_cnt, bus.err_out, bus.locked,
                 int'(cyc - last_strobe));
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("meas_cnt", int'(bus.meas_cnt), e.meas);
          check("err_out", int'(bus.err_out), e.err);
          check("locked", int'(bus.locked), e.lck);
          check("strobe_mode", int'(bus.mode_out), 1);
          if (e.chk_gap) check("strobe_gap", int'(cyc - last_strobe), PERIOD);
        end
        last_strobe = cyc;
      end else if (rst_n && bus.mode_out) begin
        check("err_out_quiet", int'(bus.err_out), 0);
      end
    end
  end

  task automatic run_windows(input int per, input int tgt, input int meas, input int err);
    int base;
    osc_per = per;
    bus.target = CNT_W'(tgt);
    repeat (20) @(posedge clk);
    #1;
    push(meas, err, 0, 1'b0);
    push(meas, err, 0, 1'b1);
    base = strobe_cnt;
    bus.en = 1'b1;
    wait_strobes(base + 2, 3 * PERIOD);
    #1;
    bus.en = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  initial begin
    int base;
    bus.en = 1'b0;
    bus.target = 16'd16;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_err_out", int'(bus.err_out), INIT_SEL);
    check("rst_mode_out", int'(bus.mode_out), 0);
    check("rst_err_valid", int'(bus.err_valid), 0);
    check("rst_meas_cnt", int'(bus.meas_cnt), 0);
    check("rst_locked", int'(bus.locked), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // zero error and lock: count 16 vs target 16, lock at 4th window;
    // target moved to 20 during window 5 takes effect in window 6
    osc_per = 4;
    repeat (20) @(posedge clk);
    #1;
    push(16, 0, 0, 1'b0);
    push(16, 0, 0, 1'b1);
    push(16, 0, 0, 1'b1);
    push(16, 0, 1, 1'b1);
    push(16, 0, 1, 1'b1);
    push(16, 1, 0, 1'b1);
    base = strobe_cnt;
    bus.en = 1'b1;
    wait_strobes(base + 4, 5 * PERIOD);
    repeat (10) @(posedge clk);
    #1;
    bus.target = 16'd20;
    wait_strobes(base + 6, 3 * PERIOD);

    // drop en mid-window
    repeat (20) @(posedge clk);
    #1;
    bus.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("endrop_mode_out", int'(bus.mode_out), 0);
    check("endrop_err_out", int'(bus.err_out), INIT_SEL);
    check("endrop_locked", int'(bus.locked), 0);
    check("endrop_err_valid", int'(bus.err_valid), 0);
    repeat (100) @(posedge clk);

    // slow: 8 edges, diff +8 -> +2
    run_windows(8, 16, 8, 2);
    // saturation: no edges, diff 65535 -> 16383 -> +255
    run_windows(0, 65535, 0, 255);
    // fast: 32 edges, diff -16 -> -4
    run_windows(2, 16, 32, -4);

    // reset mid-window
    osc_per = 4;
    bus.target = 16'd16;
    repeat (20) @(posedge clk);
    #1;
    bus.en = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    check("pre_rst_mode_out", int'(bus.mode_out), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_err_out", int'(bus.err_out), INIT_SEL);
    check("midrst_mode_out", int'(bus.mode_out), 0);
    check("midrst_err_valid", int'(bus.err_valid), 0);
    check("midrst_meas_cnt", int'(bus.meas_cnt), 0);
    check("midrst_locked", int'(bus.locked), 0);
    bus.en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);

    check("pending_expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcro_freq_det.md
# dcro_freq_det

Counter-based frequency detector and loop driver that sits directly upstream of the DCRO select-word controller. It counts rising edges of the DCRO output over a fixed window of system clocks and compares the count with a programmable target. Once per window it emits a scaled, saturated signed correction increment in incremental mode, so the controller accumulates it into the FCW. While disabled, it holds the controller in absolute mode at a preset FCW.

## Interface
- `SEL_LEN`, 8: controller select width. The increment bus is `SEL_LEN+1` bits, signed.
- `CNT_W`, 16: edge-counter and target width.
- `WIN_LEN`, 1024: measurement window length in `clk` cycles, ≥4.
- `GAIN_SHIFT`, 2: arithmetic right shift applied to the count error.
- `LOCK_TOL`, 2: maximum |error| (before shift) that counts as in-tolerance.
- `LOCK_CNT`, 4: number of consecutive in-tolerance windows needed to assert `locked`.
- `INIT_SEL`, 128: absolute FCW preset driven while idle.

Ports:
- `clk` in 1: system clock, the PLL-generated clock. One clock domain only.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run enable, level-sensitive.
- `osc_in` in 1: DCRO output, asynchronous to `clk`. Its frequency must be < f_clk/2.
- `target` in `CNT_W`: expected edge count per window, unsigned. Sampled at window start.
- `err_out` out `SEL_LEN+1`: signed value feeding the controller's `sel_in`.
- `mode_out` out 1: feeds the controller's `mode`. 0 = absolute, 1 = incremental.
- `err_valid` out 1: one-cycle strobe marking an increment on `err_out`.
- `meas_cnt` out `CNT_W`: last completed window edge count.
- `locked` out 1: frequency lock indication.

## Operation
- `osc_in` passes through a 2-flop synchronizer. A rising edge is detected as sync=1 while the previous sync=0.
- FSM states are IDLE, MEASURE, COMPUTE and OUTPUT.
- **IDLE:**
  - `mode_out`=0 and `err_out`=`INIT_SEL`.
  - Counters are held at 0 and `locked`=0.
  - If `en`=1, move to MEASURE and latch `target`.
- **MEASURE:**
  - `mode_out`=1 and `err_out`=0.
  - The window counter counts 0..`WIN_LEN`-1.
  - The edge counter increments on each detected edge and saturates at 2^`CNT_W`-1 (no wrap).
  - On the final window cycle, move to COMPUTE with the count captured. An edge detected in that final cycle is included.
- **COMPUTE:**
  - diff = `target` − count, computed as a `CNT_W+1`-bit signed value.
  - q = diff >>> `GAIN_SHIFT` (arithmetic shift, rounds toward −∞).
  - Saturate q to [−2^`SEL_LEN`, 2^`SEL_LEN`−1].
  - Update the lock run counter: increment (saturating at `LOCK_CNT`) if |diff| ≤ `LOCK_TOL`, otherwise clear it to 0.
- **OUTPUT:**
  - `err_out`=q, `err_valid`=1, `meas_cnt`=count.
  - `locked` = (lock run counter == `LOCK_CNT`).
  - Move to MEASURE with counters cleared and `target` re-latched.
- Edges detected during COMPUTE or OUTPUT are discarded.
- `err_out` is nonzero in incremental mode only during the OUTPUT cycle, because the controller accumulates every cycle.
- If `en` falls in any non-IDLE state, the next state is IDLE. No `err_valid` is issued, and the window and lock counters are cleared.

## Timing
- Reset values:
  - state = IDLE
  - `err_out` = `INIT_SEL`
  - `mode_out` = 0
  - `err_valid` = 0
  - `meas_cnt` = 0
  - `locked` = 0
  - all internal counters = 0
- All outputs are registered.
- Rising `en` at cycle n puts the FSM in MEASURE at cycle n+1. `mode_out`=1 from n+1.
- The window spans cycles n+1..n+`WIN_LEN`. COMPUTE is at n+`WIN_LEN`+1 and OUTPUT at n+`WIN_LEN`+2.
- Update period is `WIN_LEN`+2 cycles.
- Edge-to-count latency is 3 `clk` cycles (2 synchronizer stages plus the edge register).
- `en` falling at cycle m gives `mode_out`=0 and `err_out`=`INIT_SEL` at m+1. If `en` falls during OUTPUT, that cycle's strobe still completes.
- Asserting `rst_n` low mid-window forces all reset values immediately. No partial result is emitted.

## Structure
- Package `dcro_pkg` holds:
  - the state enum (IDLE, MEASURE, COMPUTE, OUTPUT);
  - the saturation limit functions for a `SEL_LEN+1`-bit signed value;
  - the shared `SEL_LEN` default, so this block and the controller agree on width.
- Sub-module `osc_edge_sync` contains the 2-flop synchronizer and the rising-edge detect. It has `clk` and `rst_n` inputs, `osc_in` input, and a single-cycle `edge_p` output.
- The FSM, counters, arithmetic and lock logic stay in the top level.

## Test plan
- **Zero error:** `WIN_LEN`=64, `target`=16, osc period 4 clk, `en` rising.
  - After ~5 windows: `meas_cnt`=16 (±1 for edge phase), `err_valid` every 66 cycles, `err_out`=0.
- **Slow oscillator:** osc period 8 clk, `target`=16.
  - `meas_cnt`=8, diff=+8, `err_out`=+2 for exactly one cycle, 0 otherwise, `mode_out`=1.
- **Fast oscillator and saturation:**
  - Osc period 2 clk: `meas_cnt`=32 and `err_out`=−4.
  - `target`=65535 with no osc edges: diff=65535, shift gives 16383, `err_out` saturates to +255.
- **Lock:** `LOCK_TOL`=2, `LOCK_CNT`=4.
  - 4 consecutive windows with count 15..17 give `locked`=1 at the 4th OUTPUT.
  - One window with count 20 gives `locked`=0 at that OUTPUT.
- **Enable and reset:**
  - Drop `en` mid-window: next cycle `mode_out`=0, `err_out`=128, `locked`=0, no `err_valid`.
  - Assert `rst_n`=0 mid-window: outputs immediately take their reset values.
